// File: rtl/fp_divider_seq_if.sv
// Request/result bundle shared by the binary32 divider and its requester.
interface fp_divider_seq_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        of;
    logic        uf;
    logic        dz;

    // Requester side: drives operands and start, observes result and status.
    modport master (
        output a, b, start,
        input  out, busy, done, of, uf, dz
    );

    // Divider side.
    modport slave (
        input  a, b, start,
        output out, busy, done, of, uf, dz
    );
endinterface

// File: rtl/fp_divider_seq.sv
// Sequential binary32 divider: restoring shift-subtract, one quotient bit per
// clock, truncation rounding, subnormals flushed to zero.
module fp_divider_seq (
    input  logic               clk,
    input  logic               reset,
    fp_divider_seq_if.slave    bus
);

    localparam int unsigned EXP_W      = 8;
    localparam int unsigned FRAC_W     = 23;
    localparam int unsigned MANT_W     = 24;
    localparam int unsigned REM_W      = 25;
    localparam int unsigned QUO_W      = 25;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned EW         = 10;
    localparam int unsigned DIV_CYCLES = 25;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched operand fields; the dividend mantissa lives in the remainder.
    logic              sign_q,  sign_d;
    logic [EXP_W-1:0]  ea_q,    ea_d;
    logic [EXP_W-1:0]  eb_q,    eb_d;
    logic [MANT_W-1:0] mb_q,    mb_d;
    logic [REM_W-1:0]  rem_q,   rem_d;
    logic [QUO_W-1:0]  quo_q,   quo_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // Registered outputs.
    logic [31:0]       out_q,   out_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              of_q,    of_d;
    logic              uf_q,    uf_d;
    logic              dz_q,    dz_d;

    // Result packing helpers.
    logic                  a_zero_c;
    logic                  b_zero_c;
    logic                  special_c;
    logic signed [EW-1:0]  exp_c;
    logic [FRAC_W-1:0]     frac_c;
    logic [REM_W-1:0]      mb_ext_c;
    logic [REM_W-1:0]      rem_sub_c;
    logic                  rem_ge_c;
    logic [31:0]           res_out_c;
    logic                  res_of_c;
    logic                  res_uf_c;
    logic                  res_dz_c;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed 25-cycle DIV phase, single NORM cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One restoring step: compare, conditionally subtract, shift.
    always_comb begin
        mb_ext_c  = {1'b0, mb_q};
        rem_ge_c  = (rem_q >= mb_ext_c);
        rem_sub_c = rem_q - mb_ext_c;
    end

    // Normalisation and special-case priority, evaluated from the final quotient.
    always_comb begin
        a_zero_c  = (ea_q == '0);
        b_zero_c  = (eb_q == '0);
        special_c = (ea_q == '1) || (eb_q == '1);

        if (quo_q[QUO_W-1]) begin
            frac_c = quo_q[FRAC_W:1];
            exp_c  = $signed(EW'(ea_q)) - $signed(EW'(eb_q)) + $signed(EW'(127));
        end else begin
            frac_c = quo_q[FRAC_W-1:0];
            exp_c  = $signed(EW'(ea_q)) - $signed(EW'(eb_q)) + $signed(EW'(126));
        end

        res_out_c = {sign_q, exp_c[EXP_W-1:0], frac_c};
        res_of_c  = 1'b0;
        res_uf_c  = 1'b0;
        res_dz_c  = 1'b0;

        if (special_c) begin
            res_out_c = QNAN;
        end else if (b_zero_c) begin
            res_dz_c  = 1'b1;
            res_out_c = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero_c) begin
            res_out_c = {sign_q, 31'h0};
        end else if (exp_c >= $signed(EW'(255))) begin
            res_of_c  = 1'b1;
            res_out_c = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (exp_c <= $signed(EW'(0))) begin
            res_uf_c  = 1'b1;
            res_out_c = {sign_q, 31'h0};
        end
    end

    // Datapath and output next values per state.
    always_comb begin
        sign_d = sign_q;
        ea_d   = ea_q;
        eb_d   = eb_q;
        mb_d   = mb_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        busy_d = busy_q;
        done_d = 1'b0;
        of_d   = of_q;
        uf_d   = uf_q;
        dz_d   = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d = bus.a[31] ^ bus.b[31];
                    ea_d   = bus.a[30:23];
                    eb_d   = bus.b[30:23];
                    mb_d   = {1'b1, bus.b[22:0]};
                    rem_d  = {2'b01, bus.a[22:0]};
                    quo_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            DIV: begin
                if (rem_ge_c) begin
                    quo_d = {quo_q[QUO_W-2:0], 1'b1};
                    rem_d = rem_sub_c << 1;
                end else begin
                    quo_d = {quo_q[QUO_W-2:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            NORM: begin
                out_d  = res_out_c;
                of_d   = res_of_c;
                uf_d   = res_uf_c;
                dz_d   = res_dz_c;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            mb_q   <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            of_q   <= 1'b0;
            uf_q   <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            sign_q <= sign_d;
            ea_q   <= ea_d;
            eb_q   <= eb_d;
            mb_q   <= mb_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
            of_q   <= of_d;
            uf_q   <= uf_d;
            dz_q   <= dz_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.of   = of_q;
    assign bus.uf   = uf_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Scoreboard bench for the sequential binary32 divider.
module tb_fp_divider_seq;

    typedef struct {
        logic [31:0] out;
        logic        of;
        logic        uf;
        logic        dz;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cycle = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    fp_divider_seq_if bus();

    fp_divider_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer long division gives the same truncated 25-bit quotient.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t              r;
        logic              s;
        int                ea;
        int                eb;
        int                e;
        longint unsigned   ma;
        longint unsigned   mb;
        longint unsigned   q;
        logic [22:0]       man;
        r.out = 32'h0;
        r.of  = 1'b0;
        r.uf  = 1'b0;
        r.dz  = 1'b0;
        r.acc = 0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            r.out = 32'h7FC0_0000;
        end else if (eb == 0) begin
            r.dz  = 1'b1;
            r.out = {s, 8'hFF, 23'h0};
        end else if (ea == 0) begin
            r.out = {s, 31'h0};
        end else begin
            ma = 64'({1'b1, a[22:0]});
            mb = 64'({1'b1, b[22:0]});
            q  = (ma << 24) / mb;
            if (q >= 64'(1 << 24)) begin
                man = 23'(q >> 1);
                e   = ea - eb + 127;
            end else begin
                man = 23'(q);
                e   = ea - eb + 126;
            end
            if (e >= 255) begin
                r.of  = 1'b1;
                r.out = {s, 8'hFF, 23'h0};
            end else if (e <= 0) begin
                r.uf  = 1'b1;
                r.out = {s, 31'h0};
            end else begin
                r.out = {s, 8'(e), man};
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] o, input logic of, input logic uf, input logic dz);
        exp_t r;
        r.out = o;
        r.of  = of;
        r.uf  = uf;
        r.dz  = dz;
        r.acc = 0;
        return r;
    endfunction

    // Result monitor: every done pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(bus.done), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check_val("out", bus.out, mon_e.out);
                check_val("flags_of_uf_dz", 32'({bus.of, bus.uf, bus.dz}),
                          32'({mon_e.of, mon_e.uf, mon_e.dz}));
                check_val("latency", cycle - mon_e.acc, 32'd26);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_val("busy_timeout", 32'(bus.busy), 32'h0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        exp_t x;
        wait_idle();
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        x     = e;
        x.acc = cycle;
        sb.push_back(x);
        bus.start = 1'b0;
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, model(a, b));
    endtask

    initial begin
        exp_t x;
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
        #1 reset = 1'b0;
        #2;
        check_val("rst_out", bus.out, 32'h0);
        check_val("rst_ctl", 32'({bus.busy, bus.done, bus.of, bus.uf, bus.dz}), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vectors with hand-derived results.
        issue(32'h40C0_0000, 32'h4000_0000, mk(32'h4040_0000, 0, 0, 0));
        issue(32'h3F80_0000, 32'h4040_0000, mk(32'h3EAA_AAAA, 0, 0, 0));
        issue(32'hC0F0_0000, 32'h4020_0000, mk(32'hC040_0000, 0, 0, 0));
        issue(32'h3F80_0000, 32'h0000_0000, mk(32'h7F80_0000, 0, 0, 1));
        issue(32'h0000_0000, 32'hC000_0000, mk(32'h8000_0000, 0, 0, 0));
        issue(32'h7F7F_FFFF, 32'h3E80_0000, mk(32'h7F80_0000, 1, 0, 0));
        issue(32'h0080_0000, 32'h4000_0000, mk(32'h0000_0000, 0, 1, 0));
        issue(32'h7F80_0000, 32'h0000_0000, mk(32'h7FC0_0000, 0, 0, 0));

        // Random operands across the full exponent range.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue_model(ra, rb);
        end

        // A start pulse while busy must be ignored.
        issue(32'h40C0_0000, 32'h4000_0000, mk(32'h4040_0000, 0, 0, 0));
        repeat (4) @(negedge clk);
        bus.a     = 32'h3F80_0000;
        bus.b     = 32'h4040_0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset mid-division: outputs clear at once, the pending result is dropped.
        issue(32'hC0F0_0000, 32'h4020_0000, mk(32'hC040_0000, 0, 0, 0));
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("midrst_out", bus.out, 32'h0);
        check_val("midrst_ctl", 32'({bus.busy, bus.done, bus.of, bus.uf, bus.dz}), 32'h0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_val("post_rst_idle", 32'({bus.busy, bus.done}), 32'h0);
        issue(32'h3F80_0000, 32'h4040_0000, mk(32'h3EAA_AAAA, 0, 0, 0));

        // Start held high: back-to-back divisions 27 clocks apart.
        wait_idle();
        bus.a     = 32'h4100_0000;
        bus.b     = 32'h4080_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        x     = mk(32'h4000_0000, 0, 0, 0);
        x.acc = cycle;
        sb.push_back(x);
        repeat (27) @(posedge clk);
        #1;
        x.acc = cycle;
        sb.push_back(x);
        check_val("b2b_busy", 32'(bus.busy), 32'h1);
        bus.start = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'h0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_divider_seq.md
# fp_divider_seq

Sequential IEEE-754 single-precision divider, the inverse companion of the shift-accumulate `fp_multiplier`. It computes `out = a / b` with a restoring shift-subtract mantissa datapath, one quotient bit per clock. It uses the same truncation rounding and the same overflow/underflow flag conventions as the multiplier, so both units can share one floating-point bench and one result bus.

## Interface
- No parameters; the format is fixed at binary32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  32  dividend, binary32; sampled only on the accepting `start` edge.
- `b`  in  32  divisor, binary32; sampled only on the accepting `start` edge.
- `start`  in  1  request; accepted only when `busy`=0.
- `out`  out  32  quotient, binary32; held until the next result is written.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `out`, `of`, `uf` and `dz` are valid from this cycle on.
- `of`  out  1  overflow.
- `uf`  out  1  underflow; the result is flushed to zero.
- `dz`  out  1  divide by zero.

## Operation
- Reset (asynchronous, `reset`=0) sets `out`=0, `busy`=0, `done`=0, `of`=0, `uf`=0 and `dz`=0, and the FSM returns to IDLE. This applies mid-operation: the division in progress is discarded.
- FSM states are IDLE, DIV and NORM.
  - IDLE: on `start`=1, latch the operands and go to DIV.
  - DIV: run for exactly 25 cycles, then go to NORM.
  - NORM: run for 1 cycle, write the outputs, pulse `done`, then go to IDLE.
- Unpack:
  - sign s = a[31]^b[31].
  - ea = a[30:23], eb = b[30:23].
  - ma = {1, a[22:0]}, mb = {1, b[22:0]}, each 24 bits.
  - An operand with exponent 0 is treated as zero (subnormals are flushed).
- DIV: restoring division.
  - The remainder register r is 25 bits and is initialised to ma.
  - Each cycle: if r >= mb, then q bit = 1 and r = (r - mb) << 1; else q bit = 0 and r = r << 1.
  - Quotient bits are shifted into a 25-bit register q, MSB first.
- NORM: the quotient lies in (0.5, 2).
  - If q[24]=1: mantissa = q[23:1], e = ea - eb + 127.
  - Else: mantissa = q[22:0], e = ea - eb + 126.
  - e is computed as a 10-bit signed value.
  - Rounding is truncation (toward zero); the remainder is discarded.
- Result priority, highest first:
  1. a or b has exponent 255: `out` = 0x7FC00000, all flags 0.
  2. b zero: `dz`=1, `out` = {s, 0xFF, 0}.
  3. a zero: `out` = {s, 31'b0}, flags 0.
  4. e >= 255: `of`=1, `out` = {s, 0xFF, 0}.
  5. e <= 0: `uf`=1, `out` = {s, 31'b0}.
  6. Otherwise: `out` = {s, e[7:0], mantissa}.
- Special cases still traverse DIV, so latency is constant.
- Flags are written together with `out` in NORM and hold until the next NORM or reset.
- `start` while `busy`=1 is ignored, and the operands are not re-sampled.
- `start` held high continuously starts a new division in the cycle after `done` (back-to-back operation).

## Timing
- `start` is sampled high at rising edge k while in IDLE.
- `busy` goes high after edge k.
- DIV occupies edges k+1 … k+25.
- NORM registers the outputs at edge k+26: `done`=1 and `busy`=0 during the cycle after edge k+26.
- Latency: 26 clocks from accepting `start` to `done`. Throughput: one result per 27 clocks.
- `done` lasts exactly one cycle. `out` keeps its value after `done` drops.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> `out` = 0x40400000, flags 0, `done` exactly 26 clocks after `start`.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated).
- 0xC0F00000 / 0x40200000 (-7.5/2.5) -> 0xC0400000.
- 0x3F800000 / 0x00000000 -> `dz`=1, `out` = 0x7F800000.
- 0x00000000 / 0xC0000000 -> `out` = 0x80000000, flags 0.
- 0x7F7FFFFF / 0x3E800000 -> `of`=1, `out` = 0x7F800000.
- 0x00800000 / 0x40000000 -> `uf`=1, `out` = 0.
- Control-path case, combined:
  - Pulse `start` again at cycle 5 with different operands: the pulse is ignored and the first result is returned.
  - Assert `reset`=0 at cycle 10 of a later division: all outputs become 0 immediately and no `done` is produced.
  - After release, a new `start` completes normally.
